zephyr_core: RTL and testbench

- Parametrised multi-cycle successor of the zephyr CPU: fetch/decode/execute sequencer with an internal N-entry register file, working ALU, flags, jumps and halt.
- Talks to a single external unified instruction/data RAM: combinational read, write on the clock edge while MEM_WE is high.
- Width, address space and register count are parameters; defaults reproduce the 8-bit / 16-word / 4-register machine.

---
 rtl/zephyr_pkg.sv | 34 +++
 rtl/zephyr_core_zregfile_n.sv | 33 +++
 rtl/zephyr_core.sv | 195 +++++++++++++++++++
 tb/tb_zephyr_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/zephyr_pkg.sv
// Shared types and encodings for the zephyr_core multi-cycle sequencer.
package zephyr_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMREAD,
        ST_MEMWRITE,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        OP_SYS   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_ALU   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SYS_NOP  = 2'b00,
        SYS_JMP  = 2'b01,
        SYS_JZ   = 2'b10,
        SYS_HALT = 2'b11
    } sys_e;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_AND = 2'b10,
        FN_XOR = 2'b11
    } func_e;

endpackage

// File: rtl/zephyr_core_zregfile_n.sv
// NREG x DATA_W register file: one write port, two combinational read ports.
module zregfile_n #(
    parameter int unsigned NREG   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_W  = $clog2(NREG)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/zephyr_core.sv
// Multi-cycle fetch/decode/execute sequencer with register file, ALU, flags, jumps and halt.
module zephyr_core
    import zephyr_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NREG   = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              FLAG_Z,
    output logic              FLAG_C,
    output logic              RETIRE,
    output logic              HALTED
);

    localparam int unsigned REG_W   = $clog2(NREG);
    localparam int unsigned OP_LSB  = REG_W + ADDR_W;
    localparam int unsigned INSTR_W = 2 + OP_LSB;

    if (DATA_W < INSTR_W || ADDR_W < 2 + REG_W || NREG < 4 || (NREG & (NREG - 1)) != 0) begin : g_bad_params
        $error("zephyr_core: illegal DATA_W/ADDR_W/NREG combination");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d, z_q, z_d, c_q, c_d;
    logic                retire_q, retire_d, halted_q, halted_d;

    op_e                 op;
    sys_e                sys;
    func_e               func;
    logic [REG_W-1:0]    rd, rs;
    logic [ADDR_W-1:0]   addr, pc_inc;
    logic [DATA_W-1:0]   rd_val, rs_val, rf_wdata, alu_res;
    logic [DATA_W:0]     alu_wide;
    logic                rf_we;

    assign op     = op_e'(ir_q[OP_LSB+1:OP_LSB]);
    assign rd     = ir_q[OP_LSB-1:ADDR_W];
    assign addr   = ir_q[ADDR_W-1:0];
    assign func   = func_e'(addr[ADDR_W-1:ADDR_W-2]);
    assign rs     = addr[REG_W-1:0];
    assign sys    = (32'(rd) > 32'd3) ? SYS_NOP : sys_e'(rd[1:0]);
    assign pc_inc = pc_q + ADDR_W'(1);

    zregfile_n #(.NREG(NREG), .DATA_W(DATA_W), .REG_W(REG_W)) u_regfile (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata),
        .raddr_a (rd),
        .rdata_a (rd_val),
        .raddr_b (rs),
        .rdata_b (rs_val)
    );

    // Extra MSB of alu_wide holds carry (ADD) or borrow (SUB); zero for logic ops.
    always_comb begin
        alu_wide = '0;
        case (func)
            FN_ADD:  alu_wide = {1'b0, rd_val} + {1'b0, rs_val};
            FN_SUB:  alu_wide = {1'b0, rd_val} - {1'b0, rs_val};
            FN_AND:  alu_wide = {1'b0, rd_val & rs_val};
            default: alu_wide = {1'b0, rd_val ^ rs_val};
        endcase
    end
    assign alu_res = alu_wide[DATA_W-1:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q        <= '0;
            ir_q        <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            retire_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            z_q         <= z_d;
            c_q         <= c_d;
            retire_q    <= retire_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (op)
                    OP_LOAD:  state_d = ST_MEMREAD;
                    OP_STORE: state_d = ST_MEMWRITE;
                    OP_SYS:   state_d = (sys == SYS_HALT) ? ST_HALT : ST_FETCH;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_MEMREAD, ST_MEMWRITE: state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_FETCH;
        endcase
    end

    // Next values of all registered outputs and architectural state; HALT holds everything.
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        z_d         = z_q;
        c_d         = c_q;
        retire_d    = 1'b0;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_res;
        case (state_q)
            ST_FETCH:  mem_addr_d = pc_q;
            ST_DECODE: ir_d = MEM_RDATA[INSTR_W-1:0];
            ST_EXECUTE: begin
                case (op)
                    OP_SYS: begin
                        retire_d = 1'b1;
                        case (sys)
                            SYS_JMP:  pc_d = addr;
                            SYS_JZ:   pc_d = z_q ? addr : pc_inc;
                            SYS_HALT: halted_d = 1'b1;
                            default:  pc_d = pc_inc;
                        endcase
                    end
                    OP_LOAD: mem_addr_d = addr;
                    OP_STORE: begin
                        mem_addr_d  = addr;
                        mem_wdata_d = rd_val;
                        mem_we_d    = 1'b1;
                    end
                    default: begin
                        rf_we    = 1'b1;
                        z_d      = (alu_res == '0);
                        c_d      = alu_wide[DATA_W];
                        pc_d     = pc_inc;
                        retire_d = 1'b1;
                    end
                endcase
            end
            ST_MEMREAD: begin
                rf_we    = 1'b1;
                rf_wdata = MEM_RDATA;
                z_d      = (MEM_RDATA == '0);
                pc_d     = pc_inc;
                retire_d = 1'b1;
            end
            ST_MEMWRITE: begin
                pc_d     = pc_inc;
                retire_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;
    assign PC_OUT    = pc_q;
    assign FLAG_Z    = z_q;
    assign FLAG_C    = c_q;
    assign RETIRE    = retire_q;
    assign HALTED    = halted_q;

endmodule

// File: tb/tb_zephyr_core.sv
// Directed bench for zephyr_core: default 8/4/4 instance plus a 16/8/8 instance, each with a behavioural RAM.
module tb_zephyr_core;

    logic        clk;
    logic        rst_n, rst2_n;

    logic [3:0]  mem_addr, pc_out;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, flag_z, flag_c, retire, halted;

    logic [7:0]  mem2_addr, pc2_out;
    logic [15:0] mem2_wdata, mem2_rdata;
    logic        mem2_we, flag2_z, flag2_c, retire2, halted2;

    logic [7:0]  mem1 [16];
    logic [15:0] mem2 [256];
    logic        ld1_en, ld2_en;
    logic [3:0]  ld1_addr;
    logic [7:0]  ld1_data, ld2_addr;
    logic [15:0] ld2_data;

    int n_tests, n_fail;
    int n_cyc, n_ret;
    logic [3:0] ret_pc [$];
    logic [3:0] first_addr;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
    } alu_vec_t;
    alu_vec_t vecs [11];

    zephyr_core u_dut (
        .CLK(clk), .RESET_N(rst_n),
        .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
        .PC_OUT(pc_out), .FLAG_Z(flag_z), .FLAG_C(flag_c), .RETIRE(retire), .HALTED(halted)
    );

    zephyr_core #(.DATA_W(16), .ADDR_W(8), .NREG(8)) u_dut2 (
        .CLK(clk), .RESET_N(rst2_n),
        .MEM_ADDR(mem2_addr), .MEM_WE(mem2_we), .MEM_WDATA(mem2_wdata), .MEM_RDATA(mem2_rdata),
        .PC_OUT(pc2_out), .FLAG_Z(flag2_z), .FLAG_C(flag2_c), .RETIRE(retire2), .HALTED(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld1_en)      mem1[ld1_addr] <= ld1_data;
        else if (mem_we) mem1[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem1[mem_addr];

    always @(posedge clk) begin
        if (ld2_en)       mem2[ld2_addr]  <= ld2_data;
        else if (mem2_we) mem2[mem2_addr] <= mem2_wdata;
    end
    assign mem2_rdata = mem2[mem2_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ld1(input logic [3:0] a, input logic [7:0] d);
        ld1_addr = a; ld1_data = d; ld1_en = 1'b1;
        @(posedge clk); #1;
        ld1_en = 1'b0;
    endtask

    task automatic ld2(input logic [7:0] a, input logic [15:0] d);
        ld2_addr = a; ld2_data = d; ld2_en = 1'b1;
        @(posedge clk); #1;
        ld2_en = 1'b0;
    endtask

    // Hold DUT1 in reset and zero its RAM.
    task automatic reset1();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) ld1(4'(i), 8'h00);
    endtask

    // Release reset, run until HALTED or the cycle budget expires.
    task automatic run1(input int max_cyc);
        n_cyc = 0; n_ret = 0;
        ret_pc.delete();
        @(negedge clk);
        rst_n = 1'b1;
        while (n_cyc < max_cyc) begin
            @(posedge clk); #1;
            n_cyc++;
            if (n_cyc == 1) first_addr = mem_addr;
            if (retire) begin
                n_ret++;
                ret_pc.push_back(pc_out);
            end
            if (halted) break;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        logic [3:0] hpc;
        int bad, r2;
        logic z_add, c_add;

        n_tests = 0; n_fail = 0;
        ld1_en = 1'b0; ld2_en = 1'b0;
        ld1_addr = '0; ld1_data = '0; ld2_addr = '0; ld2_data = '0;
        first_addr = '0;
        rst_n = 1'b0; rst2_n = 1'b0;

        vecs[0]  = '{8'hD2, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
        vecs[1]  = '{8'hD2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[2]  = '{8'hD2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{8'hD6, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{8'hD6, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b1};
        vecs[5]  = '{8'hD6, 8'h50, 8'h0F, 8'h41, 1'b0, 1'b0};
        vecs[6]  = '{8'hDA, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{8'hDA, 8'h3C, 8'hF5, 8'h34, 1'b0, 1'b0};
        vecs[8]  = '{8'hDE, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'hDE, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{8'hD1, 8'h81, 8'h00, 8'h02, 1'b0, 1'b1};

        #1;
        chk("reset_outputs", {16'h0, mem_addr, mem_we, mem_wdata, pc_out, flag_z, flag_c, retire, halted}, 32'h0);

        // ALU table: SUB R3,R2 first presets C (borrow from 0-b) so C-clearing ops are observable.
        foreach (vecs[k]) begin
            reset1();
            ld1(4'd0, 8'h5E); ld1(4'd1, 8'h6D); ld1(4'd2, 8'hF6);
            ld1(4'd3, vecs[k].instr); ld1(4'd4, 8'h9F); ld1(4'd5, 8'h30);
            ld1(4'd13, vecs[k].b); ld1(4'd14, vecs[k].a);
            run1(100);
            chk($sformatf("alu%0d_result", k), 32'(mem1[15]), 32'(vecs[k].res));
            chk($sformatf("alu%0d_z", k), 32'(flag_z), 32'(vecs[k].z));
            chk($sformatf("alu%0d_c", k), 32'(flag_c), 32'(vecs[k].c));
            chk($sformatf("alu%0d_cycles", k), 32'(n_cyc), 32'd21);
            chk($sformatf("alu%0d_retires", k), 32'(n_ret), 32'd6);
        end

        // Steady HALT: nothing moves for 100 cycles.
        hpc = pc_out; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (retire || mem_we || !halted || pc_out !== hpc) bad++;
        end
        chk("halt_steady", 32'(bad), 32'd0);

        // SUB to zero then JZ taken to 10.
        reset1();
        ld1(4'd0, 8'h5E); ld1(4'd1, 8'h6E); ld1(4'd2, 8'hD6); ld1(4'd3, 8'h2A);
        for (int i = 4; i < 10; i++) ld1(4'(i), 8'h30);
        ld1(4'd10, 8'h9F); ld1(4'd11, 8'h30); ld1(4'd14, 8'h33); ld1(4'd15, 8'hEE);
        run1(100);
        chk("jz_taken_pc", 32'(ret_pc[3]), 32'd10);
        chk("sub_zero_r1", 32'(mem1[15]), 32'h00);
        chk("sub_zero_z", 32'(flag_z), 32'd1);
        chk("sub_zero_c", 32'(flag_c), 32'd0);

        // JZ not taken, self-modifying STORE, JMP 0x1F -> 15, NOP wraps to 0 and fetches the new word.
        reset1();
        ld1(4'd0, 8'h2A); ld1(4'd1, 8'h5E); ld1(4'd2, 8'h90); ld1(4'd3, 8'h1F);
        ld1(4'd10, 8'h30); ld1(4'd14, 8'h30); ld1(4'd15, 8'h00);
        run1(100);
        chk("jz_not_taken_pc", 32'(ret_pc[0]), 32'd1);
        chk("jmp_pc", 32'(ret_pc[3]), 32'd15);
        chk("pc_wrap", 32'(ret_pc[4]), 32'd0);
        chk("selfmod_word", 32'(mem1[0]), 32'h30);
        chk("selfmod_retires", 32'(n_ret), 32'd6);
        chk("selfmod_cycles", 32'(n_cyc), 32'd20);

        // Reset asserted in the middle of MEMWRITE.
        reset1();
        ld1(4'd0, 8'h5E); ld1(4'd1, 8'h9F); ld1(4'd2, 8'h30);
        ld1(4'd14, 8'h77); ld1(4'd15, 8'h11);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("store_we_high", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstore_we_async", 32'(mem_we), 32'd0);
        chk("midstore_outputs", {16'h0, mem_addr, mem_we, mem_wdata, pc_out, flag_z, flag_c, retire, halted}, 32'h0);
        @(posedge clk); #1;
        chk("midstore_target_kept", 32'(mem1[15]), 32'h11);
        run1(100);
        chk("restart_first_fetch", 32'(first_addr), 32'd0);
        chk("restart_store_done", 32'(mem1[15]), 32'h77);
        chk("restart_cycles", 32'(n_cyc), 32'd11);

        // 16/8/8 instance: ADD overflow to zero and LOAD/STORE round trip through 0xFE.
        @(negedge clk);
        ld2(8'h00, 16'h09F0); ld2(8'h01, 16'h0AF1); ld2(8'h02, 16'h1902);
        ld2(8'h03, 16'h11FC); ld2(8'h04, 16'h0CF0); ld2(8'h05, 16'h14FE);
        ld2(8'h06, 16'h0DFE); ld2(8'h07, 16'h15FD); ld2(8'h08, 16'h0300);
        ld2(8'hF0, 16'hFFFF); ld2(8'hF1, 16'h0001);
        ld2(8'hFC, 16'h1234); ld2(8'hFD, 16'h0000); ld2(8'hFE, 16'h0000);
        @(negedge clk);
        rst2_n = 1'b1;
        r2 = 0; z_add = 1'b0; c_add = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (retire2) begin
                r2++;
                if (r2 == 3) begin
                    z_add = flag2_z;
                    c_add = flag2_c;
                end
            end
            if (halted2) break;
        end
        chk("w16_halted", 32'(halted2), 32'd1);
        chk("w16_add_z", 32'(z_add), 32'd1);
        chk("w16_add_c", 32'(c_add), 32'd1);
        chk("w16_add_result", 32'(mem2[8'hFC]), 32'h0000);
        chk("w16_store_fe", 32'(mem2[8'hFE]), 32'hFFFF);
        chk("w16_roundtrip_fd", 32'(mem2[8'hFD]), 32'hFFFF);
        chk("w16_final_flags", {30'h0, flag2_z, flag2_c}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
